// File: rtl/ms_maze_tx_chk_pkg.sv
// Shared definitions for the 15x15 maze-solver stimulus/checker (ms_maze_tx_chk).
// Holds geometry constants, the checker FSM state encoding, the error-code
// encoding reported on err_code, and the cell index helper.
package ms_pkg;

  localparam int N         = 15;
  localparam int CELLS     = N * N;
  localparam int TIMEOUT   = 4096;
  localparam int MAX_STEPS = 225;

  localparam logic [3:0] START_X = 4'd0;
  localparam logic [3:0] START_Y = 4'd0;
  localparam logic [3:0] GOAL_X  = 4'(N - 1);
  localparam logic [3:0] GOAL_Y  = 4'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_CHECK,
    S_REPORT
  } state_t;

  typedef enum logic [2:0] {
    ERR_OK            = 3'd0,
    ERR_TIMEOUT       = 3'd1,
    ERR_BAD_START     = 3'd2,
    ERR_NOT_ADJ       = 3'd3,
    ERR_WALL          = 3'd4,
    ERR_BAD_END       = 3'd5,
    ERR_WRONG_VERDICT = 3'd6,
    ERR_PROTOCOL      = 3'd7
  } err_t;

  // Bit index of cell (x,y): y*15+x, done as (y<<4)-y+x to avoid a multiplier.
  function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return ({y, 4'b0000} - {4'b0000, y}) + {4'b0000, x};
  endfunction

endpackage

// File: rtl/ms_maze_tx_chk_if.sv
// Link bundle for ms_maze_tx_chk: load handshake, serial maze to the solver,
// solver path/verdict stream back, and the result report.
//   slave  : the checker's view (drives ld_ready, in_valid, maze, done, pass,
//            err_code, step_cnt)
//   master : the environment's view (drives load and solver-response signals)
interface ms_maze_tx_chk_if;
  import ms_pkg::*;

  logic             ld_valid;
  logic             ld_ready;
  logic [CELLS-1:0] ld_maze;
  logic             ld_solvable;
  logic             in_valid;
  logic             maze;
  logic             out_valid;
  logic             maze_not_valid;
  logic [3:0]       out_x;
  logic [3:0]       out_y;
  logic             done;
  logic             pass;
  logic [2:0]       err_code;
  logic [7:0]       step_cnt;

  modport slave (
    input  ld_valid, ld_maze, ld_solvable, out_valid, maze_not_valid, out_x, out_y,
    output ld_ready, in_valid, maze, done, pass, err_code, step_cnt
  );

  modport master (
    output ld_valid, ld_maze, ld_solvable, out_valid, maze_not_valid, out_x, out_y,
    input  ld_ready, in_valid, maze, done, pass, err_code, step_cnt
  );

endinterface

// File: rtl/ms_maze_tx_chk_ser.sv
// ms_maze_ser: bit-serial maze transmitter.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start_i      load data_i and begin a 225-cycle burst next cycle
//   abort_i      drop the burst immediately (protocol error upstream)
//   data_i       maze bits, bit 0 sent first
//   in_valid_o   serial strobe, high for exactly CELLS cycles per burst
//   maze_o       current serial bit (0 when idle)
//   last_o       high on the cycle carrying bit CELLS-1
module ms_maze_ser
  import ms_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CELLS-1:0] data_i,
  output logic             in_valid_o,
  output logic             maze_o,
  output logic             last_o
);

  logic [CELLS-1:0] sh_q;
  logic [7:0]       cnt_q;
  logic             vld_q;

  assign last_o     = vld_q && (cnt_q == 8'(CELLS - 1));
  assign in_valid_o = vld_q;
  // Shifting right empties the register, so maze_o idles at 0 after a burst.
  assign maze_o     = sh_q[0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the wide shift register is reset too, since maze must read 0
      // straight out of reset.
      sh_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (abort_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (start_i) begin
      sh_q  <= data_i;
      cnt_q <= '0;
      vld_q <= 1'b1;
    end else if (vld_q) begin
      sh_q  <= sh_q >> 1;
      cnt_q <= cnt_q + 8'd1;
      if (last_o) vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ms_maze_tx_chk.sv
// ms_maze_tx_chk: drives a 15x15 maze serially into the solver, then checks
// the returned path (or "no path" verdict) against the stored maze and
// reports pass/err_code/step_cnt with a one-cycle done strobe.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          ms_maze_tx_chk_if.slave (load, serial link, result)
// Build option: define REVISIT_CHECK_EN to flag a path that re-enters an
// already visited cell (reported as NOT_ADJ). Without it revisits are legal.
module ms_maze_tx_chk
  import ms_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  ms_maze_tx_chk_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t           state_q;
  err_t             err_q;
  logic             ld_ready_q, done_q, pass_q, solvable_q;
  logic [CELLS-1:0] maze_q;
  logic [7:0]       step_cnt_q;
  logic [TW-1:0]    timer_q;
  logic [3:0]       px_q, py_q;

  logic             accept, ser_abort, ser_last;
  logic             ov, nv;
  logic [3:0]       x, y, dx, dy;
  logic [7:0]       idx;
  logic             in_range, adj, wall;
  err_t             step_err, final_err;

  assign ov        = bus.out_valid;
  assign nv        = bus.maze_not_valid;
  assign x         = bus.out_x;
  assign y         = bus.out_y;
  assign accept    = (state_q == S_IDLE) && bus.ld_valid && ld_ready_q;
  assign ser_abort = (state_q == S_SEND) && (ov || nv);

  ms_maze_ser u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept),
    .abort_i   (ser_abort),
    .data_i    (bus.ld_maze),
    .in_valid_o(bus.in_valid),
    .maze_o    (bus.maze),
    .last_o    (ser_last)
  );

`ifdef REVISIT_CHECK_EN
  logic [CELLS-1:0] visited_q;
  logic             take;
  assign take = ov && ((state_q == S_WAIT) || ((state_q == S_CHECK) && (err_q == ERR_OK)));

  always_ff @(posedge clk) begin
    if (!rst_n)                            visited_q      <= '0;
    else if (accept)                       visited_q      <= '0;
    else if (take && step_err == ERR_OK)   visited_q[idx] <= 1'b1;
  end
`endif

  // Legality of the coordinate presented this cycle, relative to the previous one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block can leave it unassigned and infer a latch.
    step_err = ERR_OK;
    idx      = cell_idx(x, y);
    dx       = (x >= px_q) ? (x - px_q) : (px_q - x);
    dy       = (y >= py_q) ? (y - py_q) : (py_q - y);
    in_range = (x <= GOAL_X) && (y <= GOAL_Y);
    adj      = (5'(dx) + 5'(dy)) == 5'd1;
    wall     = in_range ? maze_q[idx] : 1'b0;
    if (nv || step_cnt_q == 8'(MAX_STEPS))      step_err = ERR_PROTOCOL;
    else if (step_cnt_q == 8'd0) begin
      if (x != START_X || y != START_Y)         step_err = ERR_BAD_START;
    end
    else if (!in_range || !adj)                 step_err = ERR_NOT_ADJ;
`ifdef REVISIT_CHECK_EN
    else if (visited_q[idx])                    step_err = ERR_NOT_ADJ;
`endif
    if (step_err == ERR_OK && wall)             step_err = ERR_WALL;
  end

  // Verdict when the path stream ends (out_valid low in CHECK).
  always_comb begin
    final_err = ERR_OK;
    if (err_q != ERR_OK)                        final_err = err_q;
    else if (nv)                                final_err = ERR_PROTOCOL;
    else if (px_q != GOAL_X || py_q != GOAL_Y)  final_err = ERR_BAD_END;
    else if (!solvable_q)                       final_err = ERR_WRONG_VERDICT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      err_q      <= ERR_OK;
      ld_ready_q <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      solvable_q <= 1'b0;
      maze_q     <= '0;
      step_cnt_q <= '0;
      timer_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          maze_q     <= bus.ld_maze;
          solvable_q <= bus.ld_solvable;
          ld_ready_q <= 1'b0;
          err_q      <= ERR_OK;
          pass_q     <= 1'b0;
          step_cnt_q <= '0;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (ov || nv) begin
            // Drain any stray path cycles in CHECK before reporting.
            err_q   <= ERR_PROTOCOL;
            state_q <= S_CHECK;
          end else if (ser_last) begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ov) begin
            err_q      <= step_err;
            step_cnt_q <= 8'd1;
            px_q       <= x;
            py_q       <= y;
            state_q    <= S_CHECK;
          end else if (nv) begin
            err_q   <= solvable_q ? ERR_WRONG_VERDICT : ERR_OK;
            pass_q  <= !solvable_q;
            done_q  <= 1'b1;
            state_q <= S_REPORT;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            err_q   <= ERR_TIMEOUT;
            pass_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_REPORT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (ov) begin
            // After the first error the rest of the stream is only drained.
            if (err_q == ERR_OK) begin
              err_q <= step_err;
              px_q  <= x;
              py_q  <= y;
              if (step_cnt_q != 8'(MAX_STEPS)) step_cnt_q <= step_cnt_q + 8'd1;
            end
          end else begin
            err_q   <= final_err;
            pass_q  <= (final_err == ERR_OK);
            done_q  <= 1'b1;
            state_q <= S_REPORT;
          end
        end
        S_REPORT: begin
          ld_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_code = err_q;
  assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_ms_maze_tx_chk.sv
module tb_ms_maze_tx_chk;
  import ms_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ms_maze_tx_chk_if bus();

  ms_maze_tx_chk dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [7:0] steps;
    bit         chk_steps;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         errors   = 0;
  int         done_cnt = 0;
  logic [3:0] qx[$];
  logic [3:0] qy[$];
  logic [CELLS-1:0] open_m, wall_m, pat_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pass", bus.pass, mon_e.pass);
        check("err_code", bus.err_code, mon_e.err);
        if (mon_e.chk_steps) check("step_cnt", bus.step_cnt, mon_e.steps);
      end
    end
  end

  task automatic expect_res(input logic p, input logic [2:0] e, input logic [7:0] s, input bit cs);
    exp_t t;
    t.pass = p; t.err = e; t.steps = s; t.chk_steps = cs;
    exp_q.push_back(t);
  endtask

  task automatic load(input logic [CELLS-1:0] m, input logic s);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.ld_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ld_ready_before_load", bus.ld_ready, 1);
    bus.ld_maze     = m;
    bus.ld_solvable = s;
    bus.ld_valid    = 1'b1;
    @(posedge clk); #1;
    bus.ld_valid    = 1'b0;
  endtask

  // Counts the in_valid burst and compares each bit; returns on the first WAIT cycle.
  task automatic watch_send(input logic [CELLS-1:0] m);
    int cnt = 0;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.in_valid) break;
      if (cnt < CELLS && bus.maze !== m[cnt]) bad++;
      cnt++;
    end
    check("send_len", cnt, CELLS);
    check("send_bit_errs", bad, 0);
  endtask

  task automatic path_clear();
    qx.delete();
    qy.delete();
  endtask

  task automatic path_add(input int px, input int py);
    qx.push_back(4'(px));
    qy.push_back(4'(py));
  endtask

  task automatic path_full();
    path_clear();
    for (int i = 0; i < 15; i++) path_add(i, 0);
    for (int j = 1; j < 15; j++) path_add(14, j);
  endtask

  task automatic drive_path();
    for (int i = 0; i < qx.size(); i++) begin
      @(posedge clk); #1;
      bus.out_valid = 1'b1;
      bus.out_x     = qx[i];
      bus.out_y     = qy[i];
    end
    @(posedge clk); #1;
    bus.out_valid = 1'b0;
    bus.out_x     = 4'd0;
    bus.out_y     = 4'd0;
  endtask

  task automatic pulse_nv_after(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
    bus.maze_not_valid = 1'b1;
    @(posedge clk); #1;
    bus.maze_not_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int start);
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start) begin
      check("done_seen", 0, 1);
      exp_q.delete();
    end
  endtask

  initial begin
    int d0;
    bus.ld_valid       = 1'b0;
    bus.ld_maze        = '0;
    bus.ld_solvable    = 1'b0;
    bus.out_valid      = 1'b0;
    bus.maze_not_valid = 1'b0;
    bus.out_x          = 4'd0;
    bus.out_y          = 4'd0;
    open_m = '0;
    wall_m = '0;
    wall_m[16] = 1'b1;
    for (int k = 0; k < CELLS; k++) pat_m[k] = 1'($urandom_range(0, 1));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ld_ready", bus.ld_ready, 1);
    check("rst_in_valid", bus.in_valid, 0);
    check("rst_maze", bus.maze, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_step_cnt", bus.step_cnt, 0);

    // Legal 29-step path through an open maze.
    d0 = done_cnt; expect_res(1'b1, 3'd0, 8'd29, 1'b1);
    load(open_m, 1'b1); watch_send(open_m); path_full(); drive_path(); wait_done(50, d0);

    // Diagonal third step.
    d0 = done_cnt; expect_res(1'b0, 3'd3, 8'd0, 1'b0);
    load(open_m, 1'b1); watch_send(open_m);
    path_clear(); path_add(0, 0); path_add(1, 0); path_add(2, 1); path_add(2, 2);
    drive_path(); wait_done(50, d0);

    // Path through the wall at (1,1).
    d0 = done_cnt; expect_res(1'b0, 3'd4, 8'd0, 1'b0);
    load(wall_m, 1'b1); watch_send(wall_m);
    path_clear(); path_add(0, 0); path_add(1, 0); path_add(1, 1); path_add(1, 2);
    drive_path(); wait_done(50, d0);

    // Path not starting at the origin.
    d0 = done_cnt; expect_res(1'b0, 3'd2, 8'd0, 1'b0);
    load(open_m, 1'b1); watch_send(open_m);
    path_clear(); path_add(1, 0); path_add(2, 0);
    drive_path(); wait_done(50, d0);

    // Path stopping short of the goal.
    d0 = done_cnt; expect_res(1'b0, 3'd5, 8'd2, 1'b1);
    load(open_m, 1'b1); watch_send(open_m);
    path_clear(); path_add(0, 0); path_add(1, 0);
    drive_path(); wait_done(50, d0);

    // Legal path although the maze was declared unsolvable.
    d0 = done_cnt; expect_res(1'b0, 3'd6, 8'd29, 1'b1);
    load(open_m, 1'b0); watch_send(open_m); path_full(); drive_path(); wait_done(50, d0);

    // "No path" verdict, expected and unexpected.
    d0 = done_cnt; expect_res(1'b1, 3'd0, 8'd0, 1'b1);
    load(pat_m, 1'b0); watch_send(pat_m); pulse_nv_after(10); wait_done(50, d0);
    d0 = done_cnt; expect_res(1'b0, 3'd6, 8'd0, 1'b1);
    load(pat_m, 1'b1); watch_send(pat_m); pulse_nv_after(10); wait_done(50, d0);

    // Silent solver.
    d0 = done_cnt; expect_res(1'b0, 3'd1, 8'd0, 1'b1);
    load(pat_m, 1'b1); watch_send(pat_m); wait_done(5000, d0);

    // out_valid during the serial send.
    d0 = done_cnt; expect_res(1'b0, 3'd7, 8'd0, 1'b0);
    load(pat_m, 1'b1);
    repeat (100) begin @(posedge clk); #1; end
    bus.out_valid = 1'b1;
    @(posedge clk); #1;
    bus.out_valid = 1'b0;
    wait_done(50, d0);

    // Reset in the middle of the send aborts without a result.
    d0 = done_cnt;
    load(pat_m, 1'b1);
    repeat (50) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_in_valid", bus.in_valid, 0);
    check("abort_ld_ready", bus.ld_ready, 1);
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", done_cnt, d0);
    check("abort_idle_in_valid", bus.in_valid, 0);

    // Normal run after the abort.
    d0 = done_cnt; expect_res(1'b1, 3'd0, 8'd29, 1'b1);
    load(pat_m & '0, 1'b1); watch_send(open_m); path_full(); drive_path(); wait_done(50, d0);

    repeat (5) @(posedge clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
